droplong: RTL and testbench

//  Drops over-length packets on an AXIN (VALID/READY/DATA/BYTES/ABORT/LAST)

---
 rtl/droplong_pkg.sv | 32 +++
 rtl/droplong.sv | 106 ++++++++++
 tb/tb_droplong.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/droplong_pkg.sv
// Shared AXIN stream helpers: byte-count widths, the "0 = full beat" decode,
// and the state type of the over-length packet dropper.
package droplong_pkg;

  // IDLE: no packet open, MID: packet open and beats passed, DROP: swallowing.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MID  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Width of the BYTES field for a DW-bit beat.
  function automatic int axin_bytes_w(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Width of a per-packet byte counter.
  // It must hold MAXBYTES plus one more full beat without wrapping.
  function automatic int axin_count_w(input int dw, input int maxbytes);
    return $clog2(maxbytes + dw / 8) + 1;
  endfunction

  // Bytes carried by one beat.
  // A beat is full unless it is LAST with a non-zero BYTES field.
  function automatic int unsigned axin_beat_bytes(input int unsigned bytes_field,
                                                  input logic        last,
                                                  input int unsigned full);
    if (last && bytes_field != 0) return bytes_field;
    return full;
  endfunction

endpackage

// File: rtl/droplong.sv
// Over-length packet dropper for an AXIN stream. Counts bytes per packet and,
// once MAXBYTES would be exceeded, aborts the output packet and swallows the
// remainder of the input packet. One register stage, full throughput.
module droplong
  import droplong_pkg::*;
#(
  parameter int DW           = 64,
  parameter int MAXBYTES     = 1518,
  parameter bit OPT_LOWPOWER = 1'b0,
  localparam int BW          = axin_bytes_w(DW)
)(
  input  logic          S_CLK,
  input  logic          S_ARESETN,
  input  logic          S_VALID,
  output logic          S_READY,
  input  logic [DW-1:0] S_DATA,
  input  logic [BW-1:0] S_BYTES,
  input  logic          S_ABORT,
  input  logic          S_LAST,
  output logic          M_VALID,
  input  logic          M_READY,
  output logic [DW-1:0] M_DATA,
  output logic [BW-1:0] M_BYTES,
  output logic          M_ABORT,
  output logic          M_LAST
);

  localparam int          CW   = axin_count_w(DW, MAXBYTES);
  localparam int unsigned FULL = DW / 8;

  state_e        state_q;
  logic [CW-1:0] count_q;
  logic          mvalid_q, mabort_q, mlast_q;
  logic [DW-1:0] mdata_q;
  logic [BW-1:0] mbytes_q;

  logic          out_free, accept, abort_take, overflow;
  logic [CW-1:0] beat_bytes, next_count;

  // The output register can take a new beat when empty or draining.
  // While dropping, input is always accepted.
  assign out_free   = !mvalid_q || M_READY;
  assign S_READY    = (state_q == ST_DROP) || out_free;
  assign accept     = S_VALID && S_READY;
  assign abort_take = S_ABORT && (!S_VALID || S_READY);

  assign beat_bytes = CW'(axin_beat_bytes(32'(S_BYTES), S_LAST, FULL));
  assign next_count = count_q + beat_bytes;
  assign overflow   = next_count > CW'(MAXBYTES);

  // Packet FSM with registered output stage.
  // Abort handling takes priority over beat handling.
  always_ff @(posedge S_CLK or negedge S_ARESETN) begin
    if (!S_ARESETN) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      mvalid_q <= 1'b0;
      mabort_q <= 1'b0;
      mdata_q  <= '0;
      mbytes_q <= '0;
      mlast_q  <= 1'b0;
    end else begin
      // Output beat/abort consumed (or nothing held): empty the stage.
      if (out_free) begin
        mvalid_q <= 1'b0;
        mabort_q <= 1'b0;
        if (OPT_LOWPOWER) begin
          mdata_q  <= '0;
          mbytes_q <= '0;
          mlast_q  <= 1'b0;
        end
      end

      if (abort_take) begin
        // Only a packet we have started, and not already closed, is aborted.
        state_q <= ST_IDLE;
        count_q <= '0;
        if (state_q == ST_MID && (!mvalid_q || !mlast_q))
          mabort_q <= 1'b1;
      end else if (accept) begin
        if (state_q == ST_DROP) begin
          if (S_LAST) state_q <= ST_IDLE;
        end else if (overflow) begin
          // Beat would exceed MAXBYTES: abort instead of forwarding it.
          mabort_q <= 1'b1;
          count_q  <= '0;
          state_q  <= S_LAST ? ST_IDLE : ST_DROP;
        end else begin
          mvalid_q <= 1'b1;
          mdata_q  <= S_DATA;
          mbytes_q <= S_BYTES;
          mlast_q  <= S_LAST;
          count_q  <= S_LAST ? '0 : next_count;
          state_q  <= S_LAST ? ST_IDLE : ST_MID;
        end
      end
    end
  end

  assign M_VALID = mvalid_q;
  assign M_ABORT = mabort_q;
  assign M_DATA  = mdata_q;
  assign M_BYTES = mbytes_q;
  assign M_LAST  = mlast_q;

endmodule

// File: tb/tb_droplong.sv
// Bench for droplong.
// Two instances (MAXBYTES 64 and 1518) share one stimulus bus, selected by sel.
// Output is observed as a token stream (beat or ABORT).
// That stream is checked against a packet-level model built from byte arithmetic.
module tb_droplong;
  localparam int DW = 64;
  localparam int BW = 3;

  typedef struct {
    bit            ab;
    bit            l;
    logic [BW-1:0] b;
    logic [DW-1:0] d;
    int            c;
  } tok_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0;
  logic          s_valid = 1'b0, s_abort = 1'b0, s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic [BW-1:0] s_bytes = '0;
  logic          m_ready = 1'b0;

  logic          sr_a, mv_a, ma_a, ml_a, sr_b, mv_b, ma_b, ml_b;
  logic [DW-1:0] md_a, md_b;
  logic [BW-1:0] mb_a, mb_b;
  logic          s_ready, o_v, o_ab, o_l;
  logic [DW-1:0] o_d;
  logic [BW-1:0] o_b;

  int   cyc = 0;
  int   rdy_mode = 0;
  bit   mon_en = 1'b0;
  tok_t exp_q[$];
  tok_t got_q[$];
  int   acc_cyc[16];
  int   wait_cyc[16];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  droplong #(.DW(DW), .MAXBYTES(64), .OPT_LOWPOWER(1'b1)) u_a (
    .S_CLK(clk), .S_ARESETN(rst_n), .S_VALID(s_valid && !sel), .S_READY(sr_a),
    .S_DATA(s_data), .S_BYTES(s_bytes), .S_ABORT(s_abort && !sel), .S_LAST(s_last),
    .M_VALID(mv_a), .M_READY(m_ready && !sel), .M_DATA(md_a), .M_BYTES(mb_a),
    .M_ABORT(ma_a), .M_LAST(ml_a));

  droplong #(.DW(DW), .MAXBYTES(1518), .OPT_LOWPOWER(1'b0)) u_b (
    .S_CLK(clk), .S_ARESETN(rst_n), .S_VALID(s_valid && sel), .S_READY(sr_b),
    .S_DATA(s_data), .S_BYTES(s_bytes), .S_ABORT(s_abort && sel), .S_LAST(s_last),
    .M_VALID(mv_b), .M_READY(m_ready && sel), .M_DATA(md_b), .M_BYTES(mb_b),
    .M_ABORT(ma_b), .M_LAST(ml_b));

  assign s_ready = sel ? sr_b : sr_a;
  assign o_v     = sel ? mv_b : mv_a;
  assign o_ab    = sel ? ma_b : ma_a;
  assign o_l     = sel ? ml_b : ml_a;
  assign o_d     = sel ? md_b : md_a;
  assign o_b     = sel ? mb_b : mb_a;

  // Downstream ready: 0 = always, 1 = never, 2 = random 50%.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      m_ready = 1'b1;
    else if (rdy_mode == 1) m_ready = 1'b0;
    else                    m_ready = 1'($urandom_range(0, 1));
  end

  // Consumer view.
  // An abort seen on a free cycle is one ABORT token; otherwise a handshake is one beat token.
  always @(negedge clk) begin
    tok_t t;
    if (rst_n && mon_en) begin
      t = '{ab: 1'b0, l: o_l, b: o_b, d: o_d, c: cyc};
      if (o_ab && (!o_v || m_ready)) begin
        t.ab = 1'b1; t.l = 1'b0; t.b = '0; t.d = '0;
        got_q.push_back(t);
      end else if (o_v && m_ready) begin
        got_q.push_back(t);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void exp_beat(input logic [DW-1:0] d, input int by, input bit l);
    tok_t t;
    t = '{ab: 1'b0, l: l, b: BW'(by % 8), d: d, c: 0};
    exp_q.push_back(t);
  endfunction

  function automatic void exp_abort();
    tok_t t;
    t = '{ab: 1'b1, l: 1'b0, b: BW'(0), d: '0, c: 0};
    exp_q.push_back(t);
  endfunction

  // Sends one packet of len bytes and extends the expected token stream.
  // ab_at: index of the beat carrying S_ABORT (-1 none); the packet ends there.
  // ab_nov: that abort is signalled with S_VALID low.
  // rdy0_at: downstream stops being ready before this beat.
  task automatic send_pkt(input int len, input int ab_at, input bit ab_nov,
                          input int maxb, input int rdy0_at, input int gap);
    int n, sent, by, w;
    bit fwd, is_ab, lst;
    logic [DW-1:0] d;
    n = (len + 7) / 8;
    sent = 0;
    fwd = 1'b1;
    for (int i = 0; i < n; i++) begin
      by    = (i == n - 1) ? len - 8 * (n - 1) : 8;
      d     = {$urandom, $urandom};
      is_ab = (i == ab_at);
      lst   = (i == n - 1);
      if (is_ab) begin
        if (fwd && i > 0) exp_abort();
      end else if (fwd) begin
        if (sent + by > maxb) begin
          exp_abort();
          fwd = 1'b0;
        end else begin
          exp_beat(d, by, lst);
          sent += by;
        end
      end
      if (i == rdy0_at) begin rdy_mode = 1; m_ready = 1'b0; end
      if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clk); #2; end
      if (is_ab && ab_nov) begin
        s_abort = 1'b1;
        @(posedge clk); #2;
        s_abort = 1'b0;
        break;
      end
      s_valid = 1'b1; s_data = d; s_bytes = BW'(by % 8); s_last = lst; s_abort = is_ab;
      w = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        w++;
        if (w > 400) break;
      end
      if (w > 400) begin
        total++; bad++;
        $display("FAIL send_timeout beat=%0d stalled=%0d cycles limit=400", i, w);
        s_valid = 1'b0; s_abort = 1'b0; s_last = 1'b0;
        break;
      end
      @(posedge clk); #2;
      if (i < 16) begin acc_cyc[i] = cyc; wait_cyc[i] = w; end
      s_valid = 1'b0; s_abort = 1'b0; s_last = 1'b0;
      if (is_ab) break;
    end
  endtask

  task automatic wait_drain(output bit to);
    int k;
    k = 0;
    while (got_q.size() < exp_q.size() && k < 2000) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    to = (k >= 2000);
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (o_v !== 1'b0 || o_ab !== 1'b0) begin
      bad++; $display("FAIL reset_hold v=%b ab=%b want v=0 ab=0", o_v, o_ab);
    end
    total++;
    if (md_a !== '0 || ml_a !== 1'b0) begin
      bad++; $display("FAIL reset_lowpower data=%h last=%b want 0", md_a, ml_a);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    total++;
    if (s_ready !== 1'b1 || o_v !== 1'b0) begin
      bad++; $display("FAIL reset_release s_ready=%b v=%b want 1/0", s_ready, o_v);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_exact_max();
    bit to;
    exp_q.delete(); got_q.delete(); rdy_mode = 0;
    @(posedge clk); #2;
    send_pkt(64, -1, 1'b0, 64, -1, 0);
    wait_drain(to);
    total++;
    if (to || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL t1_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      total++;
      if ({got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d} !== {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d}) begin
        bad++; $display("FAIL t1_tok%0d got=%h want=%h", j,
          {got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d}, {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d});
      end
      total++;
      if (got_q[j].c !== acc_cyc[j]) begin
        bad++; $display("FAIL t1_latency beat=%0d out_cycle=%0d want=%0d", j, got_q[j].c, acc_cyc[j]);
      end
    end
  endtask

  task automatic test_over_by_one();
    bit to;
    exp_q.delete(); got_q.delete(); rdy_mode = 0;
    send_pkt(65, -1, 1'b0, 64, -1, 0);
    send_pkt(8, -1, 1'b0, 64, -1, 0);
    wait_drain(to);
    total++;
    if (to || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL t2_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      total++;
      if ({got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d} !== {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d}) begin
        bad++; $display("FAIL t2_tok%0d got=%h want=%h", j,
          {got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d}, {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d});
      end
    end
  endtask

  task automatic test_long_drop();
    bit to;
    exp_q.delete(); got_q.delete(); rdy_mode = 0;
    send_pkt(96, -1, 1'b0, 64, 9, 0);
    for (int i = 9; i < 12; i++) begin
      total++;
      if (wait_cyc[i] !== 0) begin
        bad++; $display("FAIL t3_swallow beat=%0d stall=%0d want=0", i, wait_cyc[i]);
      end
    end
    rdy_mode = 0;
    @(posedge clk); #2;
    send_pkt(16, -1, 1'b0, 64, -1, 0);
    wait_drain(to);
    total++;
    if (to || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL t3_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      total++;
      if ({got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d} !== {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d}) begin
        bad++; $display("FAIL t3_tok%0d got=%h want=%h", j,
          {got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d}, {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d});
      end
    end
  endtask

  task automatic test_upstream_abort();
    bit to;
    exp_q.delete(); got_q.delete(); rdy_mode = 0;
    send_pkt(64, 3, 1'b1, 64, -1, 0);  // abort after 3 beats, S_VALID low
    send_pkt(16, 0, 1'b0, 64, -1, 0);  // abort on first beat: silent
    send_pkt(8, 0, 1'b1, 64, -1, 0);   // bare abort in IDLE: silent
    send_pkt(64, 7, 1'b0, 64, -1, 0);  // abort together with LAST
    send_pkt(16, -1, 1'b0, 64, -1, 0);
    wait_drain(to);
    total++;
    if (to || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL t4_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      total++;
      if ({got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d} !== {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d}) begin
        bad++; $display("FAIL t4_tok%0d got=%h want=%h", j,
          {got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d}, {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d});
      end
    end
  endtask

  task automatic test_random();
    int len, n, ab, maxb, npk;
    bit to;
    for (int cfg = 0; cfg < 2; cfg++) begin
      sel  = (cfg == 1);
      maxb = (cfg == 0) ? 64 : 1518;
      npk  = (cfg == 0) ? 600 : 400;
      exp_q.delete(); got_q.delete(); rdy_mode = 2;
      @(posedge clk); #2;
      for (int p = 0; p < npk; p++) begin
        len = $urandom_range(1, 100);
        n   = (len + 7) / 8;
        ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : -1;
        send_pkt(len, ab, 1'b0, maxb, -1, 2);
      end
      wait_drain(to);
      total++;
      if (to || got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL t5_count max=%0d got=%0d want=%0d", maxb, got_q.size(), exp_q.size());
      end
      for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
        total++;
        if ({got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d} !== {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d}) begin
          bad++; $display("FAIL t5_tok%0d max=%0d got=%h want=%h", j, maxb,
            {got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d}, {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d});
        end
      end
    end
    rdy_mode = 0;
    sel = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_reset_mid();
    bit to;
    rdy_mode = 0;
    @(posedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = {$urandom, $urandom}; s_bytes = '0; s_last = 1'b0;
      @(posedge clk); #2;
    end
    s_valid = 1'b0;
    @(negedge clk);
    total++;
    if (o_v !== 1'b1) begin
      bad++; $display("FAIL t6_pre_valid v=%b want=1", o_v);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (o_v !== 1'b0 || o_ab !== 1'b0) begin
      bad++; $display("FAIL t6_async v=%b ab=%b want 0/0", o_v, o_ab);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    exp_q.delete(); got_q.delete();
    send_pkt(64, -1, 1'b0, 64, -1, 0);
    wait_drain(to);
    total++;
    if (to || got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL t6_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) begin
      total++;
      if ({got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d} !== {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d}) begin
        bad++; $display("FAIL t6_tok%0d got=%h want=%h", j,
          {got_q[j].ab, got_q[j].l, got_q[j].b, got_q[j].d}, {exp_q[j].ab, exp_q[j].l, exp_q[j].b, exp_q[j].d});
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_max();
    test_over_by_one();
    test_long_drop();
    test_upstream_abort();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
